slot_alloc_ctl: RTL and testbench

//  Allocation controller for a 64-entry slot pool (tags, buffer entries, queue slots).

---
 rtl/slot_pkg.sv | 14 +
 rtl/slot_find64.sv | 20 ++
 rtl/slot_alloc_ctl.sv | 95 +++++++++
 tb/tb_slot_alloc_ctl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/slot_pkg.sv
// Shared types and sizes for the 64-entry slot allocation controller.
package slot_pkg;

  localparam int NSLOT = 64;

  typedef logic [5:0] slot_idx_t;
  typedef logic [6:0] slot_occ_t;

  typedef enum logic {
    RUN      = 1'b0,
    THROTTLE = 1'b1
  } alloc_state_e;

endpackage

// File: rtl/slot_find64.sv
// Combinational lowest-set-bit encoder over a 64-bit vector.
module slot_find64
  import slot_pkg::*;
(
  input  logic [NSLOT-1:0] vec,
  output slot_idx_t        idx,
  output logic             hasany
);

  // Scanning from the top down leaves the lowest set bit as the final winner.
  always_comb begin
    idx = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (vec[i]) idx = slot_idx_t'(i);
    end
  end

  assign hasany = |vec;

endmodule

// File: rtl/slot_alloc_ctl.sv
// Slot pool allocator: free bitmap, lowest-index grant, occupancy count, hysteresis throttle.
// Optional double-free detection output enabled by defining SLOT_DBL_FREE_CHK_EN.
module slot_alloc_ctl
  import slot_pkg::*;
#(
  parameter logic [NSLOT-1:0] RSV_MASK = '0,
  parameter slot_occ_t        HIWAT    = 7'd56,
  parameter slot_occ_t        LOWAT    = 7'd48
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      alloc_req,
  output logic      alloc_gnt,
  output slot_idx_t alloc_idx,
  input  logic      free_vld,
  input  slot_idx_t free_idx,
  input  logic      flush,
  output slot_occ_t occ,
  output logic      full
`ifdef SLOT_DBL_FREE_CHK_EN
  ,
  output logic      dbl_free_err
`endif
);

  logic [NSLOT-1:0] free_q, free_d, avail;
  slot_occ_t        occ_d;
  alloc_state_e     state, state_d;
  logic             full_d;
  slot_idx_t        find_idx;
  logic             find_any;
  logic             free_hit;

  assign avail = free_q & ~RSV_MASK;

  slot_find64 u_find (
    .vec    (avail),
    .idx    (find_idx),
    .hasany (find_any)
  );

  assign alloc_gnt = alloc_req & (state == RUN) & find_any & ~flush;
  assign alloc_idx = alloc_gnt ? find_idx : '0;

  // A free only counts for a non-reserved slot that is currently allocated.
  assign free_hit = free_vld & ~flush & ~RSV_MASK[free_idx] & ~free_q[free_idx];

  // NOTE: every signal assigned here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    free_d  = free_q;
    occ_d   = occ;
    state_d = state;
    if (flush) begin
      free_d  = ~RSV_MASK;
      occ_d   = '0;
      state_d = RUN;
    end else begin
      if (alloc_gnt) free_d[find_idx] = 1'b0;
      if (free_hit)  free_d[free_idx] = 1'b1;
      occ_d = occ + slot_occ_t'(alloc_gnt) - slot_occ_t'(free_hit);
      case (state)
        RUN:      if (occ_d >= HIWAT) state_d = THROTTLE;
        THROTTLE: if (occ_d <= LOWAT) state_d = RUN;
        default:  state_d = RUN;
      endcase
    end
    full_d = ~|(free_d & ~RSV_MASK) | (state_d == THROTTLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values computed above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_q <= ~RSV_MASK;
      occ    <= '0;
      state  <= RUN;
      full   <= &RSV_MASK;
    end else begin
      free_q <= free_d;
      occ    <= occ_d;
      state  <= state_d;
      full   <= full_d;
    end
  end

`ifdef SLOT_DBL_FREE_CHK_EN
  // Any free that is not a valid release (reserved or already free) is flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dbl_free_err <= 1'b0;
    else     dbl_free_err <= free_vld & ~flush & ~free_hit;
  end
`endif

endmodule

// File: tb/tb_slot_alloc_ctl.sv
// Self-checking bench for slot_alloc_ctl: directed scenarios plus randomized traffic
// against a bitmap/popcount reference model. Two instances: no reservation, and slot 0 reserved.
module tb_slot_alloc_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req  [2];
  logic       fv   [2];
  logic [5:0] fidx [2];
  logic       fl   [2];
  logic       gnt  [2];
  logic [5:0] idx  [2];
  logic [6:0] occ  [2];
  logic       full [2];
`ifdef SLOT_DBL_FREE_CHK_EN
  logic       err  [2];
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state per instance
  logic [63:0] m_rsv  [2];
  int          m_hi   [2];
  int          m_lo   [2];
  logic [63:0] m_used [2];
  int          m_occ  [2];
  bit          m_thr  [2];
  bit          m_full [2];
  bit          m_err  [2];

  logic       obs_gnt, exp_gnt;
  logic [5:0] obs_idx, exp_idx;

  always #5 clk = ~clk;

  slot_alloc_ctl #(.RSV_MASK(64'h0), .HIWAT(7'd56), .LOWAT(7'd48)) dut0 (
    .clk(clk), .rst(rst), .alloc_req(req[0]), .alloc_gnt(gnt[0]), .alloc_idx(idx[0]),
    .free_vld(fv[0]), .free_idx(fidx[0]), .flush(fl[0]), .occ(occ[0]), .full(full[0])
`ifdef SLOT_DBL_FREE_CHK_EN
    , .dbl_free_err(err[0])
`endif
  );

  slot_alloc_ctl #(.RSV_MASK(64'h1), .HIWAT(7'd64), .LOWAT(7'd60)) dut1 (
    .clk(clk), .rst(rst), .alloc_req(req[1]), .alloc_gnt(gnt[1]), .alloc_idx(idx[1]),
    .free_vld(fv[1]), .free_idx(fidx[1]), .flush(fl[1]), .occ(occ[1]), .full(full[1])
`ifdef SLOT_DBL_FREE_CHK_EN
    , .dbl_free_err(err[1])
`endif
  );

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_used[d] = '0;
      m_occ[d]  = 0;
      m_thr[d]  = 1'b0;
      m_full[d] = (m_rsv[d] == '1);
      m_err[d]  = 1'b0;
    end
  endtask

  // One clock cycle on instance d: drive, sample combinational outputs, advance model.
  task automatic cycle(input int d, input logic r, input logic v, input logic [5:0] fi,
                       input logic f);
    logic vf;
    @(negedge clk);
    req[d] = r; fv[d] = v; fidx[d] = fi; fl[d] = f;
    #1;
    obs_gnt = gnt[d];
    obs_idx = idx[d];
    exp_gnt = 1'b0;
    exp_idx = '0;
    if (r && !f && !m_thr[d]) begin
      for (int i = 0; i < 64; i++) begin
        if (!m_rsv[d][i] && !m_used[d][i]) begin
          exp_gnt = 1'b1;
          exp_idx = 6'(i);
          break;
        end
      end
    end
    vf = v && !f && !m_rsv[d][fi] && m_used[d][fi];
    m_err[d] = v && !f && !vf;
    if (f) begin
      m_used[d] = '0;
      m_thr[d]  = 1'b0;
    end else begin
      if (exp_gnt) m_used[d][exp_idx] = 1'b1;
      if (vf)      m_used[d][fi] = 1'b0;
    end
    m_occ[d] = $countones(m_used[d]);
    if (m_occ[d] >= m_hi[d])      m_thr[d] = 1'b1;
    else if (m_occ[d] <= m_lo[d]) m_thr[d] = 1'b0;
    m_full[d] = m_thr[d] || ((~m_used[d] & ~m_rsv[d]) == '0);
    @(posedge clk);
    #1;
    req[d] = 1'b0; fv[d] = 1'b0; fl[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (occ[d] !== 7'd0) begin n_errors++; $display("FAIL reset_occ[%0d]: got %0d want 0", d, occ[d]); end
      n_checks++; if (full[d] !== 1'b0) begin n_errors++; $display("FAIL reset_full[%0d]: got %0b want 0", d, full[d]); end
`ifdef SLOT_DBL_FREE_CHK_EN
      n_checks++; if (err[d] !== 1'b0) begin n_errors++; $display("FAIL reset_err[%0d]: got %0b want 0", d, err[d]); end
`endif
    end
  endtask

  task automatic test_basic_grant();
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 0, 0, 0);
      n_checks++; if (obs_gnt !== 1'b1 || obs_idx !== 6'(k)) begin n_errors++; $display("FAIL basic_grant%0d: got gnt=%0b idx=%0d want gnt=1 idx=%0d", k, obs_gnt, obs_idx, k); end
    end
    n_checks++; if (occ[0] !== 7'd3) begin n_errors++; $display("FAIL basic_occ: got %0d want 3", occ[0]); end
    n_checks++; if (full[0] !== 1'b0) begin n_errors++; $display("FAIL basic_full: got %0b want 0", full[0]); end
  endtask

  task automatic test_reserved();
    cycle(1, 1, 0, 0, 0);
    n_checks++; if (obs_gnt !== 1'b1 || obs_idx !== 6'd1) begin n_errors++; $display("FAIL rsv_grant: got gnt=%0b idx=%0d want gnt=1 idx=1", obs_gnt, obs_idx); end
    cycle(1, 0, 1, 6'd0, 0);
    n_checks++; if (occ[1] !== 7'd1) begin n_errors++; $display("FAIL rsv_free_occ: got %0d want 1", occ[1]); end
`ifdef SLOT_DBL_FREE_CHK_EN
    n_checks++; if (err[1] !== 1'b1) begin n_errors++; $display("FAIL rsv_free_err: got %0b want 1", err[1]); end
`endif
    cycle(1, 1, 0, 0, 0);
    n_checks++; if (obs_gnt !== 1'b1 || obs_idx !== 6'd2) begin n_errors++; $display("FAIL rsv_next_grant: got gnt=%0b idx=%0d want gnt=1 idx=2", obs_gnt, obs_idx); end
  endtask

  task automatic test_exhaust();
    for (int k = 0; k < 61; k++) begin
      cycle(1, 1, 0, 0, 0);
      n_checks++; if (obs_gnt !== exp_gnt || obs_idx !== exp_idx) begin n_errors++; $display("FAIL exhaust_fill%0d: got gnt=%0b idx=%0d want gnt=%0b idx=%0d", k, obs_gnt, obs_idx, exp_gnt, exp_idx); end
    end
    n_checks++; if (occ[1] !== 7'd63 || full[1] !== 1'b1) begin n_errors++; $display("FAIL exhaust_state: got occ=%0d full=%0b want occ=63 full=1", occ[1], full[1]); end
    cycle(1, 1, 0, 0, 0);
    n_checks++; if (obs_gnt !== 1'b0) begin n_errors++; $display("FAIL exhaust_nogrant: got gnt=%0b want 0", obs_gnt); end
    cycle(1, 0, 1, 6'd5, 0);
    n_checks++; if (occ[1] !== 7'd62 || full[1] !== 1'b0) begin n_errors++; $display("FAIL exhaust_free: got occ=%0d full=%0b want occ=62 full=0", occ[1], full[1]); end
    cycle(1, 1, 0, 0, 0);
    n_checks++; if (obs_gnt !== 1'b1 || obs_idx !== 6'd5) begin n_errors++; $display("FAIL exhaust_regrant: got gnt=%0b idx=%0d want gnt=1 idx=5", obs_gnt, obs_idx); end
    cycle(1, 0, 0, 0, 1);
  endtask

  task automatic test_throttle();
    cycle(0, 0, 0, 0, 1);
    for (int k = 0; k < 56; k++) begin
      cycle(0, 1, 0, 0, 0);
      n_checks++; if (obs_gnt !== 1'b1 || obs_idx !== 6'(k)) begin n_errors++; $display("FAIL thr_fill%0d: got gnt=%0b idx=%0d want gnt=1 idx=%0d", k, obs_gnt, obs_idx, k); end
    end
    n_checks++; if (occ[0] !== 7'd56 || full[0] !== 1'b1) begin n_errors++; $display("FAIL thr_enter: got occ=%0d full=%0b want occ=56 full=1", occ[0], full[0]); end
    cycle(0, 1, 0, 0, 0);
    n_checks++; if (obs_gnt !== 1'b0) begin n_errors++; $display("FAIL thr_blocked: got gnt=%0b want 0", obs_gnt); end
    for (int k = 0; k < 7; k++) cycle(0, 0, 1, 6'(k), 0);
    n_checks++; if (occ[0] !== 7'd49 || full[0] !== 1'b1) begin n_errors++; $display("FAIL thr_hold: got occ=%0d full=%0b want occ=49 full=1", occ[0], full[0]); end
    cycle(0, 1, 0, 0, 0);
    n_checks++; if (obs_gnt !== 1'b0) begin n_errors++; $display("FAIL thr_hold_blocked: got gnt=%0b want 0", obs_gnt); end
    cycle(0, 0, 1, 6'd7, 0);
    n_checks++; if (occ[0] !== 7'd48 || full[0] !== 1'b0) begin n_errors++; $display("FAIL thr_exit: got occ=%0d full=%0b want occ=48 full=0", occ[0], full[0]); end
    cycle(0, 1, 0, 0, 0);
    n_checks++; if (obs_gnt !== 1'b1 || obs_idx !== 6'd0) begin n_errors++; $display("FAIL thr_resume: got gnt=%0b idx=%0d want gnt=1 idx=0", obs_gnt, obs_idx); end
  endtask

  task automatic test_same_cycle();
    cycle(0, 0, 0, 0, 1);
    for (int k = 0; k < 10; k++) cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 1, 6'd3, 0);
    n_checks++; if (obs_gnt !== 1'b1 || obs_idx !== 6'd10) begin n_errors++; $display("FAIL same_grant: got gnt=%0b idx=%0d want gnt=1 idx=10", obs_gnt, obs_idx); end
    n_checks++; if (occ[0] !== 7'd10) begin n_errors++; $display("FAIL same_occ: got %0d want 10", occ[0]); end
    cycle(0, 1, 0, 0, 0);
    n_checks++; if (obs_gnt !== 1'b1 || obs_idx !== 6'd3) begin n_errors++; $display("FAIL same_next: got gnt=%0b idx=%0d want gnt=1 idx=3", obs_gnt, obs_idx); end
  endtask

  task automatic test_flush();
    cycle(0, 0, 0, 0, 1);
    for (int k = 0; k < 56; k++) cycle(0, 1, 0, 0, 0);
    n_checks++; if (full[0] !== 1'b1) begin n_errors++; $display("FAIL flush_pre_full: got %0b want 1", full[0]); end
    cycle(0, 1, 1, 6'd4, 1);
    n_checks++; if (obs_gnt !== 1'b0) begin n_errors++; $display("FAIL flush_nogrant: got gnt=%0b want 0", obs_gnt); end
    n_checks++; if (occ[0] !== 7'd0 || full[0] !== 1'b0) begin n_errors++; $display("FAIL flush_state: got occ=%0d full=%0b want occ=0 full=0", occ[0], full[0]); end
`ifdef SLOT_DBL_FREE_CHK_EN
    n_checks++; if (err[0] !== 1'b0) begin n_errors++; $display("FAIL flush_err: got %0b want 0", err[0]); end
`endif
    cycle(0, 1, 0, 0, 0);
    n_checks++; if (obs_gnt !== 1'b1 || obs_idx !== 6'd0) begin n_errors++; $display("FAIL flush_regrant: got gnt=%0b idx=%0d want gnt=1 idx=0", obs_gnt, obs_idx); end
  endtask

  task automatic test_double_free();
    cycle(0, 0, 0, 0, 1);
    for (int k = 0; k < 2; k++) begin
      cycle(0, 0, 1, 6'd5, 0);
      n_checks++; if (occ[0] !== 7'd0) begin n_errors++; $display("FAIL dbl_occ%0d: got %0d want 0", k, occ[0]); end
`ifdef SLOT_DBL_FREE_CHK_EN
      n_checks++; if (err[0] !== 1'b1) begin n_errors++; $display("FAIL dbl_err%0d: got %0b want 1", k, err[0]); end
`endif
    end
    cycle(0, 1, 0, 0, 0);
    n_checks++; if (obs_gnt !== 1'b1 || obs_idx !== 6'd0) begin n_errors++; $display("FAIL dbl_grant: got gnt=%0b idx=%0d want gnt=1 idx=0", obs_gnt, obs_idx); end
`ifdef SLOT_DBL_FREE_CHK_EN
    n_checks++; if (err[0] !== 1'b0) begin n_errors++; $display("FAIL dbl_err_clear: got %0b want 0", err[0]); end
`endif
  endtask

  task automatic test_random();
    int d;
    logic r, v, f;
    logic [5:0] fi;
    for (int n = 0; n < 1200; n++) begin
      d  = int'($urandom_range(1, 0));
      // Alternate fill-heavy and drain-heavy phases so throttle thresholds get crossed.
      r  = ((n / 150) % 2 == 0) ? ($urandom_range(9, 0) < 8) : ($urandom_range(9, 0) < 2);
      v  = ((n / 150) % 2 == 0) ? ($urandom_range(9, 0) < 2) : ($urandom_range(9, 0) < 8);
      fi = 6'($urandom_range(63, 0));
      f  = ($urandom_range(199, 0) == 0);
      cycle(d, r, v, fi, f);
      n_checks++; if (obs_gnt !== exp_gnt || obs_idx !== exp_idx) begin n_errors++; $display("FAIL rnd_grant n=%0d d=%0d: got gnt=%0b idx=%0d want gnt=%0b idx=%0d", n, d, obs_gnt, obs_idx, exp_gnt, exp_idx); end
      n_checks++; if (occ[d] !== 7'(m_occ[d]) || full[d] !== m_full[d]) begin n_errors++; $display("FAIL rnd_regs n=%0d d=%0d: got occ=%0d full=%0b want occ=%0d full=%0b", n, d, occ[d], full[d], m_occ[d], m_full[d]); end
`ifdef SLOT_DBL_FREE_CHK_EN
      n_checks++; if (err[d] !== m_err[d]) begin n_errors++; $display("FAIL rnd_err n=%0d d=%0d: got %0b want %0b", n, d, err[d], m_err[d]); end
`endif
    end
  endtask

  task automatic test_async_reset();
    cycle(0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) cycle(0, 1, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (occ[0] !== 7'd0 || full[0] !== 1'b0) begin n_errors++; $display("FAIL areset_regs: got occ=%0d full=%0b want occ=0 full=0", occ[0], full[0]); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle(0, 1, 0, 0, 0);
    n_checks++; if (obs_gnt !== 1'b1 || obs_idx !== 6'd0) begin n_errors++; $display("FAIL areset_regrant: got gnt=%0b idx=%0d want gnt=1 idx=0", obs_gnt, obs_idx); end
  endtask

  initial begin
    m_rsv[0] = 64'h0; m_hi[0] = 56; m_lo[0] = 48;
    m_rsv[1] = 64'h1; m_hi[1] = 64; m_lo[1] = 60;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; fv[d] = 1'b0; fidx[d] = '0; fl[d] = 1'b0;
    end
    test_reset();
    test_basic_grant();
    test_reserved();
    test_exhaust();
    test_throttle();
    test_same_cycle();
    test_flush();
    test_double_free();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
